delay_arbiter: RTL and testbench

- Shares one delay counter between NUM_REQ requesters.
- A requester holds its Req line, gets a one-hot Grant, waits its own programmed length in counts, and receives a one-cycle Done pulse.
- Round-robin arbitration between requesters.
- Sits between lab-level sequencers (LED and traffic sequencing, debounce waits) and replaces per-requester copies of a standalone delay counter.

---
 rtl/delay_arbiter.sv | 143 ++++++++++++++
 tb/tb_delay_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_arbiter.sv
// rtl/delay_arbiter.sv - round-robin shared delay counter; optional prescaler under DELAY_PRESCALE_EN
module delay_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 18,
  parameter int PRESCALE      = 1000,
  parameter int PRESCALE_BITS = 10
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*WIDTH-1:0] Length,
  output logic [NUM_REQ-1:0]       Grant,
  output logic [NUM_REQ-1:0]       Done,
  output logic                     Busy,
  output logic [WIDTH-1:0]         Count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // The prescaler must be able to hold PRESCALE-1.
  if ((PRESCALE < 1) || (PRESCALE > (1 << PRESCALE_BITS))) begin : g_bad_prescale
    $error("delay_arbiter: PRESCALE does not fit in PRESCALE_BITS");
  end

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [WIDTH-1:0]     len_q, len_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [PW-1:0]        win;
  logic [PW-1:0]        cand;
  logic [WIDTH-1:0]     sel_len;
  logic                 tick;

`ifdef DELAY_PRESCALE_EN
  logic [PRESCALE_BITS-1:0] presc_q;

  assign tick = (presc_q == PRESCALE_BITS'(PRESCALE - 1));

  // Prescaler runs only while staying in COUNT; it restarts from 0 on every entry and on abort.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      presc_q <= '0;
    end else if ((state_q != S_COUNT) || (state_d != S_COUNT) || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Round-robin search: first requester above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && Req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    sel_len = Length[int'(win)*WIDTH +: WIDTH];
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    count_d = '0;
    grant_d = '0;
    done_d  = '0;
    busy_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_COUNT;
          ptr_d        = win;
          len_d        = (sel_len == '0) ? WIDTH'(1) : sel_len;
          grant_d[win] = 1'b1;
          busy_d       = 1'b1;
        end
      end
      S_COUNT: begin
        if (!Req[ptr_q]) begin
          // Abort: owner withdrew, pointer keeps it so it gets lowest priority.
          state_d = S_IDLE;
        end else if (tick && (count_q == len_q - 1'b1)) begin
          state_d       = S_DONE;
          done_d[ptr_q] = 1'b1;
          busy_d        = 1'b1;
        end else begin
          grant_d = grant_q;
          busy_d  = 1'b1;
          count_d = tick ? count_q + 1'b1 : count_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; pointer resets to the top so requester 0 wins first.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      len_q   <= '0;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign Grant = grant_q;
  assign Done  = done_q;
  assign Busy  = busy_q;
  assign Count = count_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// tb/tb_delay_arbiter.sv - self-checking bench for delay_arbiter
module tb_delay_arbiter;

  localparam int NR = 4;
  localparam int W  = 18;
`ifdef DELAY_PRESCALE_EN
  localparam int TPC = 4;
`else
  localparam int TPC = 1;
`endif

  logic              Clock;
  logic              Resetn;
  logic [NR-1:0]     Req;
  logic [NR*W-1:0]   Length;
  logic [NR-1:0]     Grant;
  logic [NR-1:0]     Done;
  logic              Busy;
  logic [W-1:0]      Count;

  int total = 0;
  int bad   = 0;

  delay_arbiter #(
    .NUM_REQ(NR), .WIDTH(W), .PRESCALE(4), .PRESCALE_BITS(10)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Req(Req), .Length(Length),
    .Grant(Grant), .Done(Done), .Busy(Busy), .Count(Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [NR-1:0] req;
    int            len;
    logic [NR-1:0] exp_grant;
    int            exp_l;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic set_len(input int len);
    for (int i = 0; i < NR; i++) Length[i*W +: W] = W'(len);
  endtask

  task automatic do_reset();
    Req    = '0;
    Resetn = 1'b0;
    step();
    Resetn = 1'b1;
    step();
  endtask

  task automatic run_vec(input vec_t v);
    int  lat;
    int  n;
    bit  cnt_ok;
    Req = v.req;
    set_len(v.len);
    lat = 0;
    while ((Grant == '0) && (lat < 8)) begin
      step();
      lat++;
    end
    check("grant_latency", 32'(lat), 32'd1);
    check("grant_value", 32'(Grant), 32'(v.exp_grant));
    n = 0;
    cnt_ok = 1'b1;
    while ((Grant != '0) && (n < v.exp_l*TPC + 8)) begin
      if (Count !== W'(n / TPC)) cnt_ok = 1'b0;
      step();
      n++;
    end
    check("grant_cycles", 32'(n), 32'(v.exp_l*TPC));
    check("count_sequence", 32'(cnt_ok), 32'd1);
    check("done_pulse", 32'(Done), 32'(v.exp_grant));
    check("busy_in_done", 32'(Busy), 32'd1);
    Req = '0;
    step();
    check("done_one_cycle", 32'(Done), 32'd0);
    check("busy_idle", 32'(Busy), 32'd0);
  endtask

  initial begin
    int order[$];
    int done_t[$];
    logic [NR-1:0] prev;
    bit ok_excl;
    bit ok_idle;
    bit pend_idle;
    int k;

    // pointer after reset is 3; each vector moves it to its winner
    vecs[0] = '{4'b0001, 5, 4'b0001, 5};
    vecs[1] = '{4'b0010, 0, 4'b0010, 1};
    vecs[2] = '{4'b0100, 7, 4'b0100, 7};
    vecs[3] = '{4'b1000, 2, 4'b1000, 2};
    vecs[4] = '{4'b1100, 4, 4'b0100, 4};
    vecs[5] = '{4'b1001, 3, 4'b1000, 3};
    vecs[6] = '{4'b0011, 1, 4'b0001, 1};

    Resetn = 1'b0;
    Req    = '0;
    Length = '0;
    step();
    step();
    check("reset_grant", 32'(Grant), 32'd0);
    check("reset_done",  32'(Done),  32'd0);
    check("reset_busy",  32'(Busy),  32'd0);
    check("reset_count", 32'(Count), 32'd0);
    Resetn = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // round robin with every requester held
    do_reset();
    Req = 4'b1111;
    set_len(3);
    prev = '0;
    ok_excl = 1'b1;
    ok_idle = 1'b1;
    pend_idle = 1'b0;
    for (int cyc = 0; (cyc < 400) && (order.size() < 5); cyc++) begin
      step();
      if ((Grant != '0) && (prev == '0)) order.push_back($clog2(Grant));
      if (Done != '0) done_t.push_back(cyc);
      if ((Done != '0) && (Grant != '0)) ok_excl = 1'b0;
      if (pend_idle && ((Grant != '0) || Busy)) ok_idle = 1'b0;
      pend_idle = (Done != '0);
      prev = Grant;
    end
    check("rr_grant_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size(); i++) check("rr_order", 32'(order[i]), 32'(i % NR));
    check("rr_done_count", 32'(done_t.size()), 32'd4);
    for (int i = 1; i < done_t.size(); i++)
      check("rr_done_spacing", 32'(done_t[i] - done_t[i-1]), 32'(3*TPC + 2));
    check("rr_done_grant_exclusive", 32'(ok_excl), 32'd1);
    check("rr_idle_after_done", 32'(ok_idle), 32'd1);
    Req = '0;
    repeat (4) step();

    // abort at Count=4, then requester 1 wins
    do_reset();
    Req = 4'b0001;
    set_len(10);
    k = 0;
    while ((Count != W'(4)) && (k < 200)) begin
      step();
      k++;
    end
    check("abort_reach_count4", 32'(Count), 32'd4);
    Req = '0;
    step();
    check("abort_grant", 32'(Grant), 32'd0);
    check("abort_done",  32'(Done),  32'd0);
    check("abort_busy",  32'(Busy),  32'd0);
    check("abort_count", 32'(Count), 32'd0);
    Req = 4'b0011;
    step();
    check("abort_next_owner", 32'(Grant), 32'b0010);
    Req = '0;
    repeat (3) step();

    // asynchronous reset mid-count
    do_reset();
    Req = 4'b0001;
    set_len(10);
    k = 0;
    while ((Count != W'(7)) && (k < 200)) begin
      step();
      k++;
    end
    check("areset_reach_count7", 32'(Count), 32'd7);
    #2;
    Resetn = 1'b0;
    #1;
    check("areset_grant", 32'(Grant), 32'd0);
    check("areset_done",  32'(Done),  32'd0);
    check("areset_busy",  32'(Busy),  32'd0);
    check("areset_count", 32'(Count), 32'd0);
    Req = 4'b1111;
    #2;
    Resetn = 1'b1;
    step();
    check("areset_first_winner", 32'(Grant), 32'b0001);
    Req = '0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
